// File: rtl/uart_tx_param.sv
// UART transmitter with runtime-configurable frame format and a small
// transmit FIFO. Frame format (divisor, data bits, parity, stop bits) is
// captured when a word leaves the FIFO and then held for the whole frame.
module uart_tx_param #(
  parameter int CLK_DIV_W  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst,
  input  logic                        i_TX_DV,
  input  logic [7:0]                  i_TX_Byte,
  input  logic [CLK_DIV_W-1:0]        i_Clks_Per_Bit,
  input  logic [3:0]                  i_Data_Bits,
  input  logic [1:0]                  i_Parity_Mode,
  input  logic                        i_Stop_Bits,
  output logic                        o_TX_Serial,
  output logic                        o_TX_Active,
  output logic                        o_TX_Done,
  output logic                        o_TX_Ready,
  output logic [$clog2(FIFO_DEPTH):0] o_FIFO_Count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int PW   = CLK_DIV_W + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_nx;

  // FIFO
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            push, pop, fifo_empty;
  logic [7:0]      head;

  // Frame datapath (latched at pop)
  logic [PW-1:0]   bit_cnt, period;
  logic [7:0]      shreg;
  logic [3:0]      nbits, bit_idx;
  logic            par_en, par_bit, stop2, stop_idx;
  logic            bit_end, frame_end;

  // Decoded live configuration, only consumed on the pop edge
  logic [PW-1:0]   period_in;
  logic [3:0]      nbits_in;
  logic [7:0]      data_mask;
  logic            par_in, par_en_in;

  assign fifo_empty   = (count == '0);
  assign o_TX_Ready   = (count < CNTW'(FIFO_DEPTH));
  assign push         = i_TX_DV && o_TX_Ready;
  assign head         = mem[rd_ptr];
  assign o_FIFO_Count = count;
  assign o_TX_Active  = (state != IDLE);
  assign bit_end      = (bit_cnt == period - PW'(1));

  // Clamp divisor and data width, precompute parity of the head word
  always_comb begin
    period_in = {1'b0, i_Clks_Per_Bit};
    if (period_in < PW'(2))
      period_in = PW'(2);
    if (i_Data_Bits < 4'd5)
      nbits_in = 4'd5;
    else if (i_Data_Bits > 4'd8)
      nbits_in = 4'd8;
    else
      nbits_in = i_Data_Bits;
    data_mask = 8'hFF >> (4'd8 - nbits_in);
    par_in    = ^(head & data_mask);
    if (i_Parity_Mode == 2'b10)
      par_in = ~par_in;
    par_en_in = (i_Parity_Mode == 2'b01) || (i_Parity_Mode == 2'b10);
  end

  // FIFO storage; contents are qualified by count, so no reset needed
  always_ff @(posedge i_Clock) begin
    if (push)
      mem[wr_ptr] <= i_TX_Byte;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Next-state logic; the last stop bit can chain straight into the next START
  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        if (bit_end)
          state_nx = DATA;
      end
      DATA: begin
        if (bit_end && (bit_idx == nbits - 4'd1))
          state_nx = par_en ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end)
          state_nx = STOP;
      end
      STOP: begin
        if (bit_end && (stop_idx == stop2)) begin
          frame_end = 1'b1;
          if (!fifo_empty) begin
            pop      = 1'b1;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and end-of-frame pulse
  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= IDLE;
      o_TX_Done <= 1'b0;
    end else begin
      state     <= state_nx;
      o_TX_Done <= frame_end;
    end
  end

  // Bit timing, shift register and per-frame configuration
  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      bit_cnt  <= '0;
      period   <= PW'(2);
      shreg    <= '0;
      nbits    <= 4'd8;
      bit_idx  <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2    <= 1'b0;
      stop_idx <= 1'b0;
    end else if (pop) begin
      bit_cnt  <= '0;
      period   <= period_in;
      shreg    <= head;
      nbits    <= nbits_in;
      bit_idx  <= '0;
      par_en   <= par_en_in;
      par_bit  <= par_in;
      stop2    <= i_Stop_Bits;
      stop_idx <= 1'b0;
    end else if (state != IDLE) begin
      if (bit_end) begin
        bit_cnt <= '0;
        if (state == DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 4'd1;
        end
        if (state == STOP)
          stop_idx <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + PW'(1);
      end
    end
  end

  // Serial line value per state; idle and stop are high
  always_comb begin
    o_TX_Serial = 1'b1;
    case (state)
      START:   o_TX_Serial = 1'b0;
      DATA:    o_TX_Serial = shreg[0];
      PARITY:  o_TX_Serial = par_bit;
      default: o_TX_Serial = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: a negedge monitor logs the line,
// a scoreboard holds expected frames pushed at write time and checked later.
module tb_uart_tx_param;

  localparam int MAXC = 20000;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic [3:0] db;
    logic [1:0] pm;
    logic       s2;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic [15:0] div_in = 16'd4;
  logic [3:0]  db_in = 4'd8;
  logic [1:0]  pm_in = 2'b00;
  logic        s2_in = 1'b0;
  logic        ser, act, done, rdy_o;
  logic [2:0]  cnt_o;

  uart_tx_param #(.CLK_DIV_W(16), .FIFO_DEPTH(4)) dut (
    .i_Clock        (clk),
    .i_Rst          (rst),
    .i_TX_DV        (dv),
    .i_TX_Byte      (byte_in),
    .i_Clks_Per_Bit (div_in),
    .i_Data_Bits    (db_in),
    .i_Parity_Mode  (pm_in),
    .i_Stop_Bits    (s2_in),
    .o_TX_Serial    (ser),
    .o_TX_Active    (act),
    .o_TX_Done      (done),
    .o_TX_Ready     (rdy_o),
    .o_FIFO_Count   (cnt_o)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic ser_log  [MAXC];
  logic done_log [MAXC];
  logic act_log  [MAXC];
  sb_t  sb[$];

  always @(negedge clk) begin
    ser_log[cyc]  = ser;
    done_log[cyc] = done;
    act_log[cyc]  = act;
    if (cyc < MAXC - 1)
      cyc = cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic int count_ones(input int sel, input int a, input int b);
    int c = 0;
    for (int i = a; i < b; i++) begin
      case (sel)
        0:       c += int'(ser_log[i]);
        1:       c += int'(done_log[i]);
        default: c += int'(act_log[i]);
      endcase
    end
    return c;
  endfunction

  function automatic logic [15:0] line_at(input int s, input int p, input int n, input int off);
    logic [15:0] v = '0;
    for (int b = 0; b < n; b++)
      v[b] = ser_log[s + b * p + off];
    return v;
  endfunction

  function automatic int period_of(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  // Reference frame: start, LSB-first data, optional parity, stop bit(s)
  function automatic void model_frame(input sb_t e, output logic [15:0] bits, output int n);
    int   nb;
    logic par;
    nb   = (e.db < 4'd5) ? 5 : ((e.db > 4'd8) ? 8 : int'(e.db));
    bits = '0;
    par  = 1'b0;
    n    = 1;
    for (int i = 0; i < nb; i++) begin
      bits[n] = e.data[i];
      par     = par ^ e.data[i];
      n++;
    end
    if (e.pm == 2'b01) begin
      bits[n] = par;
      n++;
    end else if (e.pm == 2'b10) begin
      bits[n] = ~par;
      n++;
    end
    bits[n] = 1'b1;
    n++;
    if (e.s2) begin
      bits[n] = 1'b1;
      n++;
    end
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_cfg(input sb_t e);
    div_in = e.div[15:0];
    db_in  = e.db;
    pm_in  = e.pm;
    s2_in  = e.s2;
  endtask

  // w = log index of the first sample after the accepting edge
  task automatic write_byte(input logic [7:0] d, output int w, output logic r);
    @(negedge clk);
    #2;
    dv      = 1'b1;
    byte_in = d;
    #1;
    r = rdy_o;
    @(posedge clk);
    #1;
    w  = cyc;
    dv = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ser !== 1'b1)   begin errors++; $display("FAIL reset_serial got %b exp 1", ser); end
    checks++; if (act !== 1'b0)   begin errors++; $display("FAIL reset_active got %b exp 0", act); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rdy_o); end
    checks++; if (cnt_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt_o); end
    @(negedge clk);
    #2;
    rst = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_formats();
    sb_t         tbl [8];
    sb_t         e;
    logic [15:0] eb, got;
    int          n, p, s, w;
    logic        r;
    tbl[0] = '{8'hA5, 4, 4'd8,  2'b00, 1'b0};
    tbl[1] = '{8'h35, 4, 4'd7,  2'b01, 1'b0};
    tbl[2] = '{8'h35, 4, 4'd7,  2'b10, 1'b0};
    tbl[3] = '{8'hFF, 3, 4'd5,  2'b00, 1'b1};
    tbl[4] = '{8'h5A, 0, 4'd8,  2'b00, 1'b0};
    tbl[5] = '{8'hC3, 1, 4'd15, 2'b00, 1'b0};
    tbl[6] = '{8'h3E, 2, 4'd2,  2'b11, 1'b1};
    tbl[7] = '{8'h2B, 5, 4'd6,  2'b10, 1'b1};
    for (int i = 0; i < 8; i++) begin
      set_cfg(tbl[i]);
      write_byte(tbl[i].data, w, r);
      checks++; if (r !== 1'b1) begin errors++; $display("FAIL fmt%0d_accept ready got %b exp 1", i, r); end
      sb.push_back(tbl[i]);
      if (i == 2) begin
        wait_cyc(6);
        div_in = 16'd9; db_in = 4'd5; pm_in = 2'b00; s2_in = 1'b1;
      end
      wait_cyc(12 * period_of(tbl[i].div) + 12);
      e = sb.pop_front();
      model_frame(e, eb, n);
      p = period_of(e.div);
      s = w + 1;
      checks++;
      if (ser_log[w] !== 1'b1 || ser_log[s] !== 1'b0) begin
        errors++; $display("FAIL fmt%0d_latency line got %b%b exp 10", i, ser_log[w], ser_log[s]);
      end
      got = line_at(s, p, n, 0);
      checks++; if (got !== eb) begin errors++; $display("FAIL fmt%0d_bits_first got %h exp %h", i, got, eb); end
      got = line_at(s, p, n, p - 1);
      checks++; if (got !== eb) begin errors++; $display("FAIL fmt%0d_bits_last got %h exp %h", i, got, eb); end
      checks++;
      if (done_log[s + n * p] !== 1'b1 || done_log[s + n * p + 1] !== 1'b0 ||
          count_ones(1, s, s + n * p) != 0) begin
        errors++; $display("FAIL fmt%0d_done at_end=%b after=%b early=%0d exp 1 0 0", i,
                           done_log[s + n * p], done_log[s + n * p + 1], count_ones(1, s, s + n * p));
      end
      checks++;
      if (count_ones(2, s, s + n * p) != n * p || act_log[s + n * p] !== 1'b0 || act_log[w] !== 1'b0) begin
        errors++; $display("FAIL fmt%0d_active high_cycles=%0d exp %0d", i, count_ones(2, s, s + n * p), n * p);
      end
    end
  endtask

  task automatic test_back_to_back();
    sb_t         e;
    logic [15:0] eb, got;
    int          n, p, s, w0, w, ec;
    logic        r;
    e = '{8'h11, 100, 4'd8, 2'b00, 1'b0};
    set_cfg(e);
    write_byte(8'h11, w0, r);
    sb.push_back(e);
    wait_cyc(3);
    for (int i = 0; i < 7; i++) begin
      write_byte(8'h20 + 8'(i), w, r);
      checks++;
      if (r !== (i < 4)) begin errors++; $display("FAIL b2b_ready%0d got %b exp %b", i, r, (i < 4)); end
      if (i < 4) begin
        e.data = 8'h20 + 8'(i);
        sb.push_back(e);
      end
      ec = (i < 4) ? i + 1 : 4;
      checks++;
      if (int'(cnt_o) != ec) begin errors++; $display("FAIL b2b_count%0d got %0d exp %0d", i, cnt_o, ec); end
    end
    wait_cyc(5 * 1000 + 20);
    s = w0 + 1;
    for (int k = 0; k < 5; k++) begin
      e = sb.pop_front();
      model_frame(e, eb, n);
      p = period_of(e.div);
      got = line_at(s, p, n, 0);
      checks++; if (got !== eb) begin errors++; $display("FAIL b2b_frame%0d_first got %h exp %h", k, got, eb); end
      got = line_at(s, p, n, p - 1);
      checks++; if (got !== eb) begin errors++; $display("FAIL b2b_frame%0d_last got %h exp %h", k, got, eb); end
      checks++;
      if (done_log[s + n * p] !== 1'b1 || count_ones(1, s + 1, s + n * p) != 0) begin
        errors++; $display("FAIL b2b_frame%0d_done at_end=%b early=%0d exp 1 0", k,
                           done_log[s + n * p], count_ones(1, s + 1, s + n * p));
      end
      s = s + n * p;
    end
    checks++;
    if (count_ones(2, w0 + 1, s) != s - w0 - 1 || act_log[s] !== 1'b0) begin
      errors++; $display("FAIL b2b_active high_cycles=%0d exp %0d", count_ones(2, w0 + 1, s), s - w0 - 1);
    end
    checks++;
    if (cnt_o !== 3'd0 || rdy_o !== 1'b1) begin
      errors++; $display("FAIL b2b_drained count=%0d ready=%b exp 0 1", cnt_o, rdy_o);
    end
  endtask

  task automatic test_reset_mid();
    sb_t         e;
    logic [15:0] eb, got;
    int          n, p, s, w, w2, r0;
    logic        r;
    e = '{8'h00, 4, 4'd8, 2'b00, 1'b0};
    set_cfg(e);
    write_byte(8'h00, w, r);
    write_byte(8'h77, w2, r);
    wait_cyc(12);
    checks++;
    if (ser !== 1'b0 || act !== 1'b1 || cnt_o !== 3'd1) begin
      errors++; $display("FAIL rst_mid_before line=%b active=%b count=%0d exp 0 1 1", ser, act, cnt_o);
    end
    rst = 1'b1;
    #1;
    checks++; if (ser !== 1'b1) begin errors++; $display("FAIL rst_mid_serial got %b exp 1", ser); end
    checks++;
    if (act !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags active=%b done=%b exp 0 0", act, done);
    end
    checks++;
    if (cnt_o !== 3'd0 || rdy_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid_fifo count=%0d ready=%b exp 0 1", cnt_o, rdy_o);
    end
    r0 = cyc;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(60);
    checks++;
    if (count_ones(1, r0, cyc) != 0 || count_ones(0, r0, cyc) != cyc - r0) begin
      errors++; $display("FAIL rst_mid_quiet done=%0d line_high=%0d exp 0 %0d",
                         count_ones(1, r0, cyc), count_ones(0, r0, cyc), cyc - r0);
    end
    e.data = 8'h3C;
    write_byte(8'h3C, w, r);
    sb.push_back(e);
    wait_cyc(50);
    e = sb.pop_front();
    model_frame(e, eb, n);
    p = period_of(e.div);
    s = w + 1;
    got = line_at(s, p, n, 0);
    checks++; if (got !== eb) begin errors++; $display("FAIL rst_after_bits got %h exp %h", got, eb); end
    checks++;
    if (done_log[s + n * p] !== 1'b1 || count_ones(1, s, s + n * p) != 0) begin
      errors++; $display("FAIL rst_after_done at_end=%b early=%0d exp 1 0",
                         done_log[s + n * p], count_ones(1, s, s + n * p));
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
